// File: rtl/dmem_noc_arbiter_2to1.sv
// Two-master to one-port data-memory arbiter with a single outstanding transaction.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin conflict resolution; default is fixed m0 priority.

package urv_cfg;
  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;
endpackage

package urv_typedef;
  typedef struct packed {
    logic [urv_cfg::XLEN-1:0] addr;
    logic [urv_cfg::XLEN-1:0] wdata;
    logic [urv_cfg::BE_W-1:0] be;
    logic                     we;
  } mem_req_t;

  typedef struct packed {
    logic [urv_cfg::XLEN-1:0] rdata;
    logic                     err;
    logic                     resp_last;
  } mem_resp_t;
endpackage

// state | meaning
// ARB   | no transaction outstanding; requests are arbitrated and forwarded
// RESP  | one transaction outstanding; response beats routed to owner_q
module dmem_noc_arbiter_2to1
  import urv_typedef::*;
(
  input  logic      clk,
  input  logic      rstn,

  input  logic      m0_req_valid,
  output logic      m0_req_ready,
  input  mem_req_t  m0_req,
  output logic      m0_resp_valid,
  input  logic      m0_resp_ready,
  output mem_resp_t m0_resp,

  input  logic      m1_req_valid,
  output logic      m1_req_ready,
  input  mem_req_t  m1_req,
  output logic      m1_resp_valid,
  input  logic      m1_resp_ready,
  output mem_resp_t m1_resp,

  output logic      sn_req_valid,
  input  logic      sn_req_ready,
  output mem_req_t  sn_req,
  input  logic      sn_resp_valid,
  output logic      sn_resp_ready,
  input  mem_resp_t sn_resp
);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [0:0] state_q;
  logic       owner_q;
  logic       hold_vld_q;
  logic       hold_id_q;

  logic       gnt;
  logic       conflict_gnt;
  logic       in_arb;
  logic       in_resp;
  logic       gnt_valid;
  logic       req_hs;
  logic       owner_resp_ready;
  logic       resp_last_hs;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_q;

  assign conflict_gnt = ~last_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_q <= 1'b1;
    end else if (req_hs) begin
      last_q <= gnt;
    end
  end
`else
  assign conflict_gnt = 1'b0;
`endif

  // Outputs are qualified by rstn so nothing handshakes while reset is held.
  assign in_arb  = rstn && (state_q == ST_ARB);
  assign in_resp = rstn && (state_q == ST_RESP);

  always_comb begin
    gnt = 1'b0;
    if (hold_vld_q) begin
      gnt = hold_id_q;
    end else if (m0_req_valid && m1_req_valid) begin
      gnt = conflict_gnt;
    end else if (m1_req_valid) begin
      gnt = 1'b1;
    end
  end

  assign gnt_valid    = gnt ? m1_req_valid : m0_req_valid;
  assign sn_req_valid = in_arb && gnt_valid;
  assign sn_req       = gnt ? m1_req : m0_req;
  assign m0_req_ready = in_arb && sn_req_ready && !gnt;
  assign m1_req_ready = in_arb && sn_req_ready && gnt;
  assign req_hs       = sn_req_valid && sn_req_ready;

  assign owner_resp_ready = owner_q ? m1_resp_ready : m0_resp_ready;
  assign sn_resp_ready    = in_resp && owner_resp_ready;
  assign m0_resp_valid    = in_resp && !owner_q && sn_resp_valid;
  assign m1_resp_valid    = in_resp && owner_q && sn_resp_valid;
  assign m0_resp          = sn_resp;
  assign m1_resp          = sn_resp;
  assign resp_last_hs     = sn_resp_valid && sn_resp_ready && sn_resp.resp_last;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_ARB;
      owner_q    <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_id_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (req_hs) begin
            state_q    <= ST_RESP;
            owner_q    <= gnt;
            hold_vld_q <= 1'b0;
          end else if (sn_req_valid) begin
            // Freeze the grant until the router takes the pending request.
            hold_vld_q <= 1'b1;
            hold_id_q  <= gnt;
          end
        end
        ST_RESP: begin
          if (resp_last_hs) begin
            state_q <= ST_ARB;
          end
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_noc_arbiter_2to1.sv
// Bench for dmem_noc_arbiter_2to1: vector table, directed corner sequences, random vs. model.
module tb_dmem_noc_arbiter_2to1;
  import urv_typedef::*;

  logic      clk;
  logic      rstn;
  logic      m0_req_valid, m1_req_valid;
  logic      m0_req_ready, m1_req_ready;
  mem_req_t  m0_req, m1_req;
  logic      m0_resp_valid, m1_resp_valid;
  logic      m0_resp_ready, m1_resp_ready;
  mem_resp_t m0_resp, m1_resp;
  logic      sn_req_valid, sn_req_ready;
  mem_req_t  sn_req;
  logic      sn_resp_valid, sn_resp_ready;
  mem_resp_t sn_resp;

  int total = 0;
  int bad   = 0;

  dmem_noc_arbiter_2to1 dut (
    .clk(clk), .rstn(rstn),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req(m0_req),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp(m0_resp),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req(m1_req),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp(m1_resp),
    .sn_req_valid(sn_req_valid), .sn_req_ready(sn_req_ready), .sn_req(sn_req),
    .sn_resp_valid(sn_resp_valid), .sn_resp_ready(sn_resp_ready), .sn_resp(sn_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req_valid  = 1'b0;
    m1_req_valid  = 1'b0;
    sn_req_ready  = 1'b0;
    sn_resp_valid = 1'b0;
    m0_resp_ready = 1'b0;
    m1_resp_ready = 1'b0;
    sn_resp       = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  function automatic mem_req_t rand_req();
    mem_req_t r;
    r.addr  = $urandom;
    r.wdata = $urandom;
    r.be    = 4'($urandom_range(0, 15));
    r.we    = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic mem_resp_t rand_resp();
    mem_resp_t r;
    r.rdata     = $urandom;
    r.err       = 1'($urandom_range(0, 1));
    r.resp_last = ($urandom_range(0, 2) == 0);
    return r;
  endfunction

  // {sn_req_valid, m0_req_ready, m1_req_ready, sn_resp_ready, any m*_resp_valid}
  typedef struct {
    logic       rst;
    logic       m0v;
    logic       m1v;
    logic       rdy;
    logic       rv;
    logic [4:0] exp;
    logic       sel;
  } vec_t;

  vec_t vecs[8];

  // Queue of accepted grants with their cycle numbers.
  int acc_id[$];
  int acc_cyc[$];

  // Reference model state (integers, spec-level view).
  bit mdl_busy;
  int mdl_owner, mdl_lock, mdl_last;

  initial begin
    int k, cyc, g, winner;
    bit tog;
    logic [5:0] e;
    int exp_ids[4];

    rstn = 1'b0;
    idle_inputs();
    m0_req = '{addr:32'h0000_1000, wdata:32'hAAAA_0000, be:4'hF, we:1'b1};
    m1_req = '{addr:32'h0000_2000, wdata:32'h5555_0000, be:4'h3, we:1'b0};

    // ---------------- vector table ----------------
    vecs[0] = '{rst:1, m0v:1, m1v:1, rdy:1, rv:1, exp:5'b00000, sel:0};
    vecs[1] = '{rst:0, m0v:0, m1v:0, rdy:1, rv:0, exp:5'b01000, sel:0};
    vecs[2] = '{rst:0, m0v:1, m1v:0, rdy:1, rv:0, exp:5'b11000, sel:0};
    vecs[3] = '{rst:0, m0v:0, m1v:1, rdy:1, rv:0, exp:5'b10100, sel:1};
    vecs[4] = '{rst:0, m0v:1, m1v:1, rdy:1, rv:0, exp:5'b11000, sel:0};
    vecs[5] = '{rst:0, m0v:0, m1v:1, rdy:0, rv:0, exp:5'b10000, sel:1};
    vecs[6] = '{rst:0, m0v:0, m1v:0, rdy:0, rv:1, exp:5'b00000, sel:0};
    vecs[7] = '{rst:0, m0v:1, m1v:1, rdy:0, rv:1, exp:5'b10000, sel:0};
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rst) begin
        rstn = 1'b0;
      end else begin
        do_reset();
      end
      m0_req_valid  = vecs[i].m0v;
      m1_req_valid  = vecs[i].m1v;
      sn_req_ready  = vecs[i].rdy;
      sn_resp_valid = vecs[i].rv;
      sn_resp       = '{rdata:32'hDEAD_0000 + 32'(i), err:1'b0, resp_last:1'b1};
      m0_resp_ready = 1'b1;
      m1_resp_ready = 1'b1;
      #4;
      chk($sformatf("vec%0d_ctl", i),
          {sn_req_valid, m0_req_ready, m1_req_ready, sn_resp_ready, m0_resp_valid | m1_resp_valid},
          vecs[i].exp);
      if (!vecs[i].rst) chk($sformatf("vec%0d_payload", i), sn_req, vecs[i].sel ? m1_req : m0_req);
      tick();
    end

    // ---------------- both masters saturating, single-beat responses ----------------
    do_reset();
    m0_req_valid  = 1'b1;
    m1_req_valid  = 1'b1;
    sn_req_ready  = 1'b1;
    sn_resp_valid = 1'b1;
    sn_resp       = '{rdata:32'h1234_5678, err:1'b0, resp_last:1'b1};
    m0_resp_ready = 1'b1;
    m1_resp_ready = 1'b1;
    acc_id.delete();
    acc_cyc.delete();
    for (int c = 0; c < 10; c++) begin
      #4;
      if (m0_req_valid && m0_req_ready) begin acc_id.push_back(0); acc_cyc.push_back(c); end
      if (m1_req_valid && m1_req_ready) begin acc_id.push_back(1); acc_cyc.push_back(c); end
      tick();
    end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_ids = '{0, 1, 0, 1};
`else
    exp_ids = '{0, 0, 0, 0};
`endif
    chk("sat_accept_count_ge4", acc_id.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < acc_id.size()) chk($sformatf("sat_grant%0d", i), acc_id[i], exp_ids[i]);
      if (i > 0 && i < acc_cyc.size()) chk($sformatf("sat_bubble%0d", i), (acc_cyc[i] - acc_cyc[i-1]) >= 2, 1'b1);
    end

    // ---------------- m1 stalled, m0 arrives mid-stall ----------------
    do_reset();
    m1_req_valid = 1'b1;
    m1_req = '{addr:32'h0000_3000, wdata:32'hCAFE_F00D, be:4'hC, we:1'b1};
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) m0_req_valid = 1'b1;
      #4;
      chk($sformatf("stall_c%0d_valid", c), sn_req_valid, 1'b1);
      chk($sformatf("stall_c%0d_payload", c), sn_req, m1_req);
      chk($sformatf("stall_c%0d_rdy", c), {m0_req_ready, m1_req_ready}, 2'b00);
      tick();
    end
    sn_req_ready = 1'b1;
    #4;
    chk("stall_c4_payload", sn_req, m1_req);
    chk("stall_c4_accept", {m0_req_ready, m1_req_ready}, 2'b01);
    tick();
    m1_req_valid = 1'b0;
    #4;
    chk("stall_resp_no_req", {sn_req_valid, m0_req_ready, m1_req_ready}, 3'b000);

    // ---------------- 4-beat response with toggling ready ----------------
    do_reset();
    m0_req_valid = 1'b1;
    sn_req_ready = 1'b1;
    #4;
    chk("burst_accept", m0_req_ready, 1'b1);
    tick();
    m0_req_valid = 1'b0;
    k = 0; cyc = 0; tog = 1'b1;
    while (k < 4 && cyc < 20) begin
      sn_resp_valid = 1'b1;
      sn_resp = '{rdata:32'hB000_0000 + 32'(k), err:1'b0, resp_last:(k == 3)};
      m0_resp_ready = tog;
      #4;
      chk("burst_m1_quiet", m1_resp_valid, 1'b0);
      chk("burst_m0_valid", m0_resp_valid, 1'b1);
      chk("burst_sn_ready", sn_resp_ready, tog);
      if (tog) begin
        chk($sformatf("burst_beat%0d", k), m0_resp.rdata, 32'hB000_0000 + 32'(k));
        k++;
      end
      tick();
      tog = ~tog;
      cyc++;
    end
    chk("burst_beats", k, 4);
    sn_resp = '{rdata:32'hEEEE_EEEE, err:1'b0, resp_last:1'b0};
    m0_resp_ready = 1'b1;
    m1_req_valid  = 1'b1;
    #4;
    chk("burst_arb_reentered", {sn_resp_ready, m0_resp_valid, m1_req_ready}, 3'b001);
    tick();

    // ---------------- reset in the middle of a burst ----------------
    do_reset();
    m0_req_valid = 1'b1;
    sn_req_ready = 1'b1;
    tick();
    m0_req_valid  = 1'b0;
    m0_resp_ready = 1'b1;
    m1_resp_ready = 1'b1;
    sn_resp_valid = 1'b1;
    sn_resp = '{rdata:32'hC000_0001, err:1'b0, resp_last:1'b0};
    #4;
    chk("rst_beat1_hs", {m0_resp_valid, sn_resp_ready}, 2'b11);
    tick();
    rstn = 1'b0;
    m0_req_valid = 1'b1;
    m1_req_valid = 1'b1;
    sn_resp = '{rdata:32'hC000_0002, err:1'b0, resp_last:1'b0};
    #4;
    chk("rst_outputs_low",
        {sn_req_valid, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, sn_resp_ready}, 6'b0);
    tick();
    rstn = 1'b1;
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    for (int b = 3; b <= 4; b++) begin
      sn_resp = '{rdata:32'hC000_0000 + 32'(b), err:1'b0, resp_last:(b == 4)};
      #4;
      chk($sformatf("rst_stale_beat%0d", b), {sn_resp_ready, m0_resp_valid, m1_resp_valid}, 3'b000);
      tick();
    end
    sn_resp_valid = 1'b0;
    m1_req_valid = 1'b1;
    #4;
    chk("rst_new_m1_accept", {sn_req_valid, m1_req_ready, m0_req_ready}, 3'b110);
    chk("rst_new_m1_payload", sn_req, m1_req);
    tick();
    m1_req_valid  = 1'b0;
    sn_resp_valid = 1'b1;
    sn_resp = '{rdata:32'hD00D_0001, err:1'b0, resp_last:1'b1};
    #4;
    chk("rst_m1_resp", {m1_resp_valid, m0_resp_valid, sn_resp_ready}, 3'b101);
    chk("rst_m1_resp_data", m1_resp.rdata, 32'hD00D_0001);
    tick();

    // ---------------- random traffic vs. reference model ----------------
    do_reset();
    mdl_busy = 0; mdl_owner = 0; mdl_lock = -1; mdl_last = 1;
    for (int c = 0; c < 800; c++) begin
      rstn = ($urandom_range(0, 39) != 0);
      if (!mdl_busy && mdl_lock == 0) m0_req_valid = 1'b1;
      else begin m0_req_valid = 1'($urandom_range(0, 1)); m0_req = rand_req(); end
      if (!mdl_busy && mdl_lock == 1) m1_req_valid = 1'b1;
      else begin m1_req_valid = 1'($urandom_range(0, 1)); m1_req = rand_req(); end
      sn_req_ready  = 1'($urandom_range(0, 1));
      sn_resp_valid = 1'($urandom_range(0, 1));
      sn_resp       = rand_resp();
      m0_resp_ready = 1'($urandom_range(0, 1));
      m1_resp_ready = 1'($urandom_range(0, 1));
      #4;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      winner = 1 - mdl_last;
`else
      winner = 0;
`endif
      if (mdl_lock >= 0) g = mdl_lock;
      else if (m0_req_valid && m1_req_valid) g = winner;
      else if (m1_req_valid) g = 1;
      else g = 0;
      // {sn_req_valid, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, sn_resp_ready}
      e = '0;
      if (rstn && !mdl_busy) begin
        e[5] = (g == 0) ? m0_req_valid : m1_req_valid;
        e[4] = sn_req_ready && (g == 0);
        e[3] = sn_req_ready && (g == 1);
      end else if (rstn && mdl_busy) begin
        e[2] = sn_resp_valid && (mdl_owner == 0);
        e[1] = sn_resp_valid && (mdl_owner == 1);
        e[0] = (mdl_owner == 0) ? m0_resp_ready : m1_resp_ready;
      end
      chk("rnd_ctl", {sn_req_valid, m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid, sn_resp_ready}, e);
      if (rstn && !mdl_busy) chk("rnd_sn_req", sn_req, (g == 1) ? m1_req : m0_req);
      if (rstn && mdl_busy) chk("rnd_resp_fanout", {m0_resp, m1_resp}, {sn_resp, sn_resp});
      if (!rstn) begin
        mdl_busy = 0; mdl_owner = 0; mdl_lock = -1; mdl_last = 1;
      end else if (!mdl_busy) begin
        if (e[5] && sn_req_ready) begin
          mdl_busy = 1; mdl_owner = g; mdl_last = g; mdl_lock = -1;
        end else if (e[5]) begin
          mdl_lock = g;
        end
      end else if (sn_resp_valid && e[0] && sn_resp.resp_last) begin
        mdl_busy = 0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_noc_arbiter_2to1.md
DMEM_NOC_ARBITER_2TO1 -- requirements
Module: dmem_noc_arbiter_2to1

Interface
REQ-001 SHALL have no parameters; payload types are mem_req_t and mem_resp_t from urv_typedef, and configuration comes from urv_cfg.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 m0_req_valid, m1_req_valid  input  1  master request valid (m0 = LSU, m1 = debug/DMA).
REQ-005 m0_req_ready, m1_req_ready  output  1  master request accepted.
REQ-006 m0_req, m1_req  input  mem_req_t  master request payload.
REQ-007 m0_resp_valid, m1_resp_valid  output  1  response beat valid to master.
REQ-008 m0_resp_ready, m1_resp_ready  input  1  master accepts response beat.
REQ-009 m0_resp, m1_resp  output  mem_resp_t  response payload to master.
REQ-010 sn_req_valid  output  1  request valid to the downstream 1-to-4 router master port.
REQ-011 sn_req_ready  input  1  router accepts request.
REQ-012 sn_req  output  mem_req_t  muxed request payload.
REQ-013 sn_resp_valid  input  1  router response beat valid.
REQ-014 sn_resp_ready  output  1  response beat accepted.
REQ-015 sn_resp  input  mem_resp_t  router response payload; resp_last marks the final beat.

Function
REQ-016 SHALL implement a 2-state FSM: ARB (no outstanding transaction) and RESP (one outstanding transaction owned by owner_q).
REQ-017 ARB: SHALL select gnt = the held grant if hold_vld=1; otherwise the sole requester; on conflict, the REQ-033 policy winner.
REQ-018 ARB: sn_req_valid SHALL equal gnt's req_valid and sn_req SHALL equal gnt's req, combinationally (zero-cycle request latency).
REQ-019 ARB: mX_req_ready SHALL be sn_req_ready AND (gnt==X); the non-granted master's ready SHALL be 0.
REQ-020 If sn_req_valid=1 and sn_req_ready=0, hold_vld SHALL be set with hold_id=gnt, so grant stays fixed until acceptance (no valid/payload switching mid-handshake).
REQ-021 On request handshake: FSM->RESP, owner_q<=gnt, last_q<=gnt, hold_vld<=0.
REQ-022 RESP: all mX_req_ready and sn_req_valid SHALL be 0 (one outstanding transaction total).
REQ-023 RESP: m{owner_q}_resp_valid SHALL equal sn_resp_valid, its resp SHALL equal sn_resp, and sn_resp_ready SHALL equal m{owner_q}_resp_ready.
REQ-024 RESP: the other master's resp_valid SHALL be 0, and both mX_resp payloads SHALL be driven with sn_resp.
REQ-025 Multi-beat: non-last response beats SHALL keep RESP; a handshake with resp_last=1 SHALL move FSM->ARB next cycle.
REQ-026 One bubble cycle minimum between a last-response handshake and the next request acceptance; no same-cycle re-accept.
REQ-027 ARB with sn_resp_valid=1 (spurious): sn_resp_ready SHALL be 0, nothing forwarded, state unchanged.
REQ-028 Masters SHALL be able to drop req_valid only if not granted; behaviour for a granted master retracting valid is undefined.

Reset
REQ-029 When rstn=0 at a clk edge: FSM=ARB, owner_q=0, last_q=1, hold_vld=0, hold_id=0.
REQ-030 While rstn=0, all valid and ready outputs SHALL be forced to 0; payload outputs are don't-care.
REQ-031 Reset mid-transaction SHALL abandon the outstanding response; post-reset beats are spurious per REQ-027.

Configuration
REQ-032 Macro DMEM_ARB_ROUND_ROBIN_EN selects the conflict policy.
REQ-033 Defined: on conflict, grant the master != last_q (round-robin). Undefined: m0 always wins, and last_q is unused.

Verification
REQ-034 Both masters valid from reset, sn_req_ready=1, single-beat resp_last=1, macro defined -> grants m0, m1, m0, m1; each accept is separated by >=1 bubble.
REQ-035 Same as REQ-034, macro undefined -> m0 granted every transaction while m0_req_valid stays high; m1 is never granted.
REQ-036 m1 valid, sn_req_ready=0 for 3 cycles, then m0 rises in cycle 2 -> sn_req keeps m1 payload stable; m1 is accepted in cycle 4.
REQ-037 m0 read with 4 response beats (resp_last on beat 4) and m0_resp_ready toggling 1,0,1,0 -> 4 beats delivered in order to m0; m1_resp_valid stays 0; ARB re-entered after beat 4.
REQ-038 rstn=0 during beat 2 of 4 -> outputs 0; after release, remaining sn_resp beats are not acknowledged (sn_resp_ready=0); new m1 request accepted normally.
REQ-039 sn_resp_valid=1 in ARB with no requests -> sn_resp_ready=0; both mX_resp_valid=0.
